// File: rtl/input_command_arbiter.sv
// Input command arbiter: turns keycodes and gravity ticks into single move
// commands for the game FSM over a valid/ready handshake.
module input_command_arbiter #(
  parameter logic [7:0] LEFT_KEYCODE         = 8'h04,
  parameter logic [7:0] RIGHT_KEYCODE        = 8'h07,
  parameter logic [7:0] LEFT_ROTATE_KEYCODE  = 8'h14,
  parameter logic [7:0] RIGHT_ROTATE_KEYCODE = 8'h1a,
  parameter logic [7:0] HARD_DROP_KEYCODE    = 8'h2c,
  parameter logic [7:0] HOLDPIECE_KEYCODE    = 8'h0f,
  parameter int         DAS_DELAY            = 16,
  parameter int         ARR_PERIOD           = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] keyboardinput,
  input  logic       gravity_tick,
  input  logic       flush,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic [2:0] queue_count,
  output logic       overflow
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_ROTL  = 3'd3;
  localparam logic [2:0] OP_ROTR  = 3'd4;
  localparam logic [2:0] OP_FALL  = 3'd5;
  localparam logic [2:0] OP_HDROP = 3'd6;
  localparam logic [2:0] OP_HOLD  = 3'd7;

  localparam int DAS_W = $clog2(DAS_DELAY + 1);
  localparam int ARR_W = (ARR_PERIOD > 1) ? $clog2(ARR_PERIOD) : 1;

  typedef enum logic {S_IDLE, S_PRESENT} state_e;

  function automatic logic [2:0] key_map(input logic [7:0] k);
    logic [2:0] op;
    op = OP_NONE;
    if      (k == LEFT_KEYCODE)         op = OP_LEFT;
    else if (k == RIGHT_KEYCODE)        op = OP_RIGHT;
    else if (k == LEFT_ROTATE_KEYCODE)  op = OP_ROTL;
    else if (k == RIGHT_ROTATE_KEYCODE) op = OP_ROTR;
    else if (k == HARD_DROP_KEYCODE)    op = OP_HDROP;
    else if (k == HOLDPIECE_KEYCODE)    op = OP_HOLD;
    return op;
  endfunction

  logic [7:0]       prev_key_q;
  logic [DAS_W-1:0] das_cnt_q, das_cnt_d;
  logic [ARR_W-1:0] arr_cnt_q, arr_cnt_d;
  logic             ev_vld_q, ev_vld_d;
  logic [2:0]       ev_op_q, ev_op_d;
  logic [3:0][2:0]  fifo_q;
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q, count_d;
  logic             grav_q, grav_d;
  logic             hold_used_q, hold_used_d;
  logic             rr_last_q;   // 1: gravity won last, 0: key FIFO won last
  logic             src_q;       // source of the presented command, 1 = gravity
  logic             cmd_valid_q;
  logic [2:0]       cmd_op_q;
  state_e           state_q;

  logic [2:0] key_op, head_op;
  logic       key_held, lr_held, das_sat, repeat_ev;
  logic       xfer, pop, wr_try, wr, full, pick_grav;

  // Key edge detection and DAS/ARR auto-repeat.
  always_comb begin
    key_op    = key_map(keyboardinput);
    key_held  = (keyboardinput == prev_key_q);
    lr_held   = key_held && (key_op == OP_LEFT || key_op == OP_RIGHT);
    das_sat   = (das_cnt_q == DAS_W'(DAS_DELAY));
    repeat_ev = lr_held && das_sat && (arr_cnt_q == '0);
    das_cnt_d = '0;
    arr_cnt_d = '0;
    if (lr_held && !flush) begin
      das_cnt_d = das_sat ? das_cnt_q : das_cnt_q + 1'b1;
      if (das_sat)
        arr_cnt_d = (arr_cnt_q == ARR_W'(ARR_PERIOD - 1)) ? '0 : arr_cnt_q + 1'b1;
    end
    // An edge seen during flush is dropped; prev_key still tracks the input.
    ev_vld_d = !flush && ((!key_held && key_op != OP_NONE) || repeat_ev);
    ev_op_d  = ev_vld_d ? key_op : OP_NONE;
  end

  // FIFO, gravity and hold bookkeeping.
  always_comb begin
    head_op     = fifo_q[rd_ptr_q];
    xfer        = cmd_valid_q && cmd_ready && !flush;
    pop         = xfer && !src_q;
    full        = (count_q == 3'd4);
    wr_try      = ev_vld_q && !(ev_op_q == OP_HOLD && hold_used_q);
    wr          = wr_try && !flush && (!full || pop);
    overflow    = wr_try && !flush && full && !pop;
    count_d     = flush ? 3'd0 : count_q + {2'b00, wr} - {2'b00, pop};
    grav_d      = flush ? 1'b0 : gravity_tick ? 1'b1 : (xfer && src_q) ? 1'b0 : grav_q;
    hold_used_d = flush ? 1'b0 : (xfer && cmd_op_q == OP_HOLD) ? 1'b1 : hold_used_q;
    // HARD_DROP at the head pre-empts gravity regardless of round-robin state.
    pick_grav   = grav_q && (count_q == 3'd0 || (head_op != OP_HDROP && !rr_last_q));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_key_q  <= 8'h00;
      das_cnt_q   <= '0;
      arr_cnt_q   <= '0;
      ev_vld_q    <= 1'b0;
      ev_op_q     <= OP_NONE;
      fifo_q      <= '0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      grav_q      <= 1'b0;
      hold_used_q <= 1'b0;
    end else begin
      prev_key_q  <= keyboardinput;
      das_cnt_q   <= das_cnt_d;
      arr_cnt_q   <= arr_cnt_d;
      ev_vld_q    <= ev_vld_d;
      ev_op_q     <= ev_op_d;
      count_q     <= count_d;
      grav_q      <= grav_d;
      hold_used_q <= hold_used_d;
      if (flush) begin
        wr_ptr_q <= 2'd0;
        rd_ptr_q <= 2'd0;
      end else begin
        if (wr) begin
          fifo_q[wr_ptr_q] <= ev_op_q;
          wr_ptr_q         <= wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

  // Output FSM: select in IDLE, hold stable in PRESENT until transfer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NONE;
      src_q       <= 1'b0;
      rr_last_q   <= 1'b1;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != 3'd0 || grav_q) begin
            state_q     <= S_PRESENT;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= pick_grav ? OP_FALL : head_op;
            src_q       <= pick_grav;
          end
        end
        S_PRESENT: begin
          if (xfer) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_NONE;
            rr_last_q   <= src_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_input_command_arbiter.sv
// Scoreboard bench for input_command_arbiter: stimulus pushes expected ops,
// a monitor pops and compares on every handshake transfer.
module tb_input_command_arbiter;

  localparam int DAS = 16;
  localparam int ARR = 4;

  localparam logic [7:0] K_L  = 8'h04;
  localparam logic [7:0] K_R  = 8'h07;
  localparam logic [7:0] K_RL = 8'h14;
  localparam logic [7:0] K_RR = 8'h1a;
  localparam logic [7:0] K_HD = 8'h2c;
  localparam logic [7:0] K_HO = 8'h0f;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] kbd = 8'h00;
  logic       gtick = 1'b0;
  logic       flush = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [2:0] queue_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  logic [2:0] exp_q[$];

  input_command_arbiter #(.DAS_DELAY(DAS), .ARR_PERIOD(ARR)) dut (
    .CLK(CLK), .RESET(RESET), .keyboardinput(kbd), .gravity_tick(gtick),
    .flush(flush), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .queue_count(queue_count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [2:0] code2op(input logic [7:0] c);
    case (c)
      K_L:  return 3'd1;
      K_R:  return 3'd2;
      K_RL: return 3'd3;
      K_RR: return 3'd4;
      K_HD: return 3'd6;
      K_HO: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // All drives happen 1 time unit after a rising edge.
  task automatic press(input logic [7:0] code, input int hold, input int gap, input logic push);
    kbd = code;
    if (push) exp_q.push_back(code2op(code));
    cyc(hold);
    kbd = 8'h00;
    cyc(gap);
  endtask

  task automatic tick(input int n);
    repeat (n) begin gtick = 1'b1; cyc(1); gtick = 1'b0; cyc(1); end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || cmd_valid || queue_count != 0) && t < 400) begin
      cyc(1); t++;
    end
    checks++;
    if (t >= 400) begin
      errors++;
      $display("FAIL %s drain: %0d expected ops never seen, queue_count=%0d", name, exp_q.size(), queue_count);
      exp_q.delete();
    end
    cyc(8);
  endtask

  task automatic monitor();
    logic       held = 1'b0;
    logic [2:0] hop = 3'd0;
    logic [2:0] e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        held = 1'b0;
      end else begin
        if (overflow) ovf_cnt++;
        if (held) begin
          checks++;
          if (!cmd_valid || cmd_op != hop) begin
            errors++;
            $display("FAIL stable: valid=%0d op=%0d, required valid=1 op=%0d", cmd_valid, cmd_op, hop);
          end
        end
        if (!cmd_valid) begin
          checks++;
          if (cmd_op != 3'd0) begin
            errors++;
            $display("FAIL idle_op: op=%0d while cmd_valid=0, required 0", cmd_op);
          end
        end
        if (cmd_valid && cmd_ready && !flush) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer: unexpected op %0d transferred, none expected", cmd_op);
          end else begin
            e = exp_q.pop_front();
            if (cmd_op != e) begin
              errors++;
              $display("FAIL xfer: op %0d transferred, expected %0d", cmd_op, e);
            end
          end
        end
        held = cmd_valid && !cmd_ready && !flush;
        hop  = cmd_op;
      end
    end
  endtask

  initial begin
    int n, ovf0, hold, gap, idx, t;
    logic [7:0] keys [5];
    logic [7:0] code;
    keys[0] = K_L; keys[1] = K_R; keys[2] = K_RL; keys[3] = K_RR; keys[4] = K_HD;
    fork monitor(); join_none

    // Reset state
    cyc(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_ovf", overflow, 0);
    RESET = 1'b0;
    cyc(2);

    // Single LEFT tap
    cmd_ready = 1'b1;
    press(K_L, 1, 4, 1'b1);
    drain("left_tap");
    chk("left_tap_count", queue_count, 0);

    // RIGHT held 40 cycles: initial event plus repeats at das_cnt DAS, DAS+ARR, ... <= 38
    n = 1;
    for (int v = DAS; v <= 40 - 2; v++) if ((v - DAS) % ARR == 0) n++;
    repeat (n) exp_q.push_back(3'd2);
    press(K_R, 40, 4, 1'b0);
    drain("das_right");

    // Overflow: five keys with consumer stalled, fifth dropped
    cmd_ready = 1'b0;
    ovf0 = ovf_cnt;
    press(K_L, 2, 2, 1'b1);
    press(K_R, 2, 2, 1'b1);
    press(K_RL, 2, 2, 1'b1);
    press(K_RR, 2, 2, 1'b1);
    press(K_HD, 2, 2, 1'b0);
    cyc(4);
    chk("ovf_count", queue_count, 4);
    chk("ovf_pulses", ovf_cnt - ovf0, 1);
    chk("ovf_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    drain("ovf_drain");

    // Gravity coalescing and round-robin: ROT_L presented first, then gravity wins once
    cmd_ready = 1'b0;
    press(K_RL, 2, 2, 1'b1);
    press(K_RR, 2, 2, 1'b0);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd4);
    cyc(3);
    tick(3);
    chk("grav_count", queue_count, 2);
    cmd_ready = 1'b1;
    drain("grav_rr");

    // HARD_DROP at head beats pending gravity even when gravity is owed its turn
    cmd_ready = 1'b0;
    press(K_RL, 2, 2, 1'b1);
    press(K_HD, 2, 2, 1'b1);
    exp_q.push_back(3'd5);
    cyc(3);
    tick(2);
    cmd_ready = 1'b1;
    drain("hd_prio");

    // HOLD lockout
    flush = 1'b1; cyc(1); flush = 1'b0; cyc(2);
    ovf0 = ovf_cnt;
    press(K_HO, 2, 4, 1'b1);
    drain("hold_first");
    press(K_HO, 2, 4, 1'b0);
    drain("hold_second");
    chk("hold_ovf", ovf_cnt - ovf0, 0);
    chk("hold_count", queue_count, 0);
    flush = 1'b1; cyc(1); flush = 1'b0; cyc(2);
    press(K_HO, 2, 4, 1'b1);
    drain("hold_after_flush");

    // Key held across a flush must not re-fire
    kbd = K_RR;
    exp_q.push_back(3'd4);
    cyc(6);
    flush = 1'b1; cyc(1); flush = 1'b0;
    cyc(6);
    kbd = 8'h00;
    drain("held_flush");

    // Flush while presenting with cmd_ready=1: nothing transferred
    cmd_ready = 1'b0;
    press(K_RL, 2, 2, 1'b0);
    press(K_RR, 2, 2, 1'b0);
    press(K_L, 2, 2, 1'b0);
    cyc(3);
    chk("fl_count_pre", queue_count, 3);
    chk("fl_valid_pre", cmd_valid, 1);
    cmd_ready = 1'b1;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("fl_valid", cmd_valid, 0);
    chk("fl_count", queue_count, 0);
    cyc(10);

    // Asynchronous reset mid-stream
    cmd_ready = 1'b0;
    press(K_RL, 2, 2, 1'b0);
    press(K_RR, 2, 2, 1'b0);
    cyc(3);
    chk("ar_count_pre", queue_count, 2);
    @(posedge CLK); #3;
    RESET = 1'b1;
    #1;
    chk("ar_valid", cmd_valid, 0);
    chk("ar_op", cmd_op, 0);
    chk("ar_count", queue_count, 0);
    chk("ar_ovf", overflow, 0);
    @(posedge CLK); @(posedge CLK); #3;
    RESET = 1'b0;
    @(posedge CLK); #1;
    cmd_ready = 1'b1;
    cyc(10);

    // Randomized key stream with random backpressure, never more than 4 outstanding
    ovf0 = ovf_cnt;
    for (int k = 0; k < 80; k++) begin
      t = 0;
      while (exp_q.size() >= 4 && t < 300) begin
        cmd_ready = ($urandom_range(0, 3) != 0);
        cyc(1); t++;
      end
      if (t >= 300) begin
        checks++; errors++;
        $display("FAIL rand_wait: consumer never drained, %0d outstanding", exp_q.size());
      end
      idx = $urandom_range(0, 4);
      code = keys[idx];
      if (code == kbd) code = keys[(idx + 1) % 5];
      kbd = code;
      exp_q.push_back(code2op(code));
      hold = $urandom_range(1, 10);
      repeat (hold) begin cmd_ready = ($urandom_range(0, 3) != 0); cyc(1); end
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        kbd = 8'h00;
        repeat (gap) begin cmd_ready = ($urandom_range(0, 3) != 0); cyc(1); end
      end
    end
    kbd = 8'h00;
    cmd_ready = 1'b1;
    drain("random");
    chk("rand_ovf", ovf_cnt - ovf0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
